cntr_seq_ctrl: RTL and testbench
================================

// Module: cntr_seq_ctrl
// PURPOSE
// - Wishbone-programmable sequencer for the user-area up counter driving io_out[8:0].
// - Counter has load and count-enable inputs; this block loads a start value, paces counting with a prescaler,
//   detects the terminal count, and either stops or auto-reloads.
// - Sits in user_project_wrapper between the MGMT SoC Wishbone slave port and the counter.
// - Raises an interrupt on user_irq[0].
// PARAMETERS
// - CNT_W    9             counter width; matches io_out[8:0]
// - PRE_W    16            prescaler width
// - BASE_ADR 32'h3000_0000 Wishbone base address; decode uses wbs_adr_i[31:8]
// PORTS
// - wb_clk_i        in   1      sole clock
// - wb_rst_i        in   1      asynchronous, active-high reset
// - wbs_cyc_i       in   1      Wishbone cycle
// - wbs_stb_i       in   1      Wishbone strobe
// - wbs_we_i        in   1      Wishbone write enable
// - wbs_sel_i       in   4      byte selects
// - wbs_adr_i       in   32     byte address
// - wbs_dat_i       in   32     write data
// - wbs_ack_o       out  1      acknowledge
// - wbs_dat_o       out  32     read data
// - cnt_val_i       in   CNT_W  current counter value
// - cnt_load_o      out  1      1-cycle load strobe to counter
// - cnt_load_val_o  out  CNT_W  value loaded on cnt_load_o
// - cnt_en_o        out  1      1-cycle increment strobe to counter
// - irq_o           out  1      level interrupt
// BEHAVIOUR
// - Reset: all registers 0, FSM IDLE; wbs_ack_o, wbs_dat_o, cnt_load_o, cnt_en_o and irq_o are 0; cnt_load_val_o = 0.
// - Wishbone access:
//   - wbs_ack_o asserts the cycle after cyc&stb&!ack, for exactly 1 cycle.
//   - Byte lanes honoured per wbs_sel_i.
//   - Unmapped offsets: acked, read 0, write ignored.
// - Register map (byte offsets):
//   - 0x00 CTRL: [0] START (W1 pulse), [1] STOP (W1 pulse), [2] AUTORELOAD, [3] IRQ_EN, [4] PAUSE (see CONFIGURATION).
//   - 0x04 PRESCALE[PRE_W-1:0]
//   - 0x08 LOAD[CNT_W-1:0]
//   - 0x0C TERM[CNT_W-1:0]
//   - 0x10 STATUS: [1:0] state, [2] DONE sticky (W1C) -- read-only except W1C.
//   - 0x14 COUNT: cnt_val_i, read-only.
// - FSM states: IDLE=0, LOAD=1, RUN=2, DONE=3.
//   - IDLE/DONE: START -> LOAD.
//   - LOAD: cnt_load_o=1 and cnt_load_val_o=LOAD for 1 cycle; prescaler cleared; -> RUN next cycle.
//   - RUN: prescaler counts 0..PRESCALE; tick when prescaler==PRESCALE (PRESCALE=0 -> tick every cycle).
//     - On tick with cnt_val_i!=TERM: cnt_en_o=1 for that cycle.
//     - On tick with cnt_val_i==TERM: DONE sticky set; no cnt_en_o; AUTORELOAD ? -> LOAD : -> DONE.
// - Timing: first cnt_en_o occurs PRESCALE+1 cycles after the LOAD cycle.
// - STOP in any state -> IDLE next cycle; prescaler cleared; counter value untouched.
// - Priority rules:
//   - START and STOP in the same write: STOP wins.
//   - START while in RUN: restarts via LOAD.
//   - DONE set and W1C in the same cycle: set wins.
// - TERM < LOAD is legal: the counter wraps 2^CNT_W-1 -> 0 itself; the sequencer keeps ticking until cnt_val_i==TERM.
// - LOAD/TERM/PRESCALE writes during RUN take effect on the next compare or load; no restart.
// - irq_o = DONE & IRQ_EN, registered (1-cycle latency after DONE sets).
// - Reset mid-operation returns everything to reset values immediately (asynchronous).
// CONFIGURATION
// - Macro CNTR_SEQ_PAUSE_EN defined: CTRL[4] PAUSE is R/W.
//   - While PAUSE=1 in RUN, the prescaler holds and cnt_en_o=0.
//   - Clearing PAUSE resumes from the held prescaler value.
//   - STATUS state still reads RUN.
// - Macro undefined: CTRL[4] reads 0, writes ignored; no pause logic is synthesised.
// STRUCTURE
// - Package cntr_seq_pkg:
//   - state encoding localparams (S_IDLE..S_DONE)
//   - register offset localparams (REG_CTRL..REG_COUNT)
//   - CTRL bit-index localparams
// - Sub-module cntr_seq_prescaler:
//   - ports: clr, run, limit[PRE_W], tick output
//   - instantiated once
// - Wishbone decode, registers and FSM stay in cntr_seq_ctrl.
// TESTING
// - Reset: assert wb_rst_i mid-RUN -> all outputs 0 in the same cycle; STATUS reads 0 after release.
// - One-shot run: LOAD=5, TERM=8, PRESCALE=0, START -> cnt_load_o once with value 5, then exactly 3 cnt_en_o pulses;
//   DONE=1; state=DONE.
// - Prescale plus interrupt: PRESCALE=3, IRQ_EN=1 -> cnt_en_o every 4 cycles; irq_o rises 1 cycle after DONE;
//   W1C of STATUS[2] clears irq_o.
// - Wrap and auto-reload: LOAD=510, TERM=1, AUTORELOAD=1 -> 3 cnt_en_o pulses (510->511->0->1), then cnt_load_o
//   with 510, repeating.
// - Collisions: a CTRL write of 0x3 during RUN -> IDLE with no load; a START during RUN -> a cnt_load_o pulse the
//   next cycle.
// - Bus: a read of offset 0x20 acks with 0; back-to-back strobes give one 1-cycle ack per access; with
//   CNTR_SEQ_PAUSE_EN, PAUSE=1 suppresses cnt_en_o for 20 cycles.

Source files
------------

// File: rtl/cntr_seq_pkg.sv
// Shared constants for the counter sequencer: FSM state codes, Wishbone
// register offsets and the bit positions inside the CTRL and STATUS words.
package cntr_seq_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [7:0] REG_CTRL     = 8'h00;
   localparam logic [7:0] REG_PRESCALE = 8'h04;
   localparam logic [7:0] REG_LOAD     = 8'h08;
   localparam logic [7:0] REG_TERM     = 8'h0C;
   localparam logic [7:0] REG_STATUS   = 8'h10;
   localparam logic [7:0] REG_COUNT    = 8'h14;

   localparam int CTRL_START = 0;
   localparam int CTRL_STOP  = 1;
   localparam int CTRL_AUTO  = 2;
   localparam int CTRL_IRQEN = 3;
   localparam int CTRL_PAUSE = 4;

   localparam int STAT_DONE = 2;

   // Expands the four Wishbone byte selects into a per-bit write mask.
   function automatic logic [31:0] lane_mask_of(input logic [3:0] sel);
      return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
   endfunction

endpackage

// File: rtl/cntr_seq_prescaler.sv
// Prescaler for the counter sequencer: counts 0..limit while run is high and
// emits a one-cycle tick on the limit value, then wraps to 0. clr forces the
// count back to 0; with run low and clr low the count holds (used for pause).
module cntr_seq_prescaler #(
   parameter int PRE_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             run,
   input  logic [PRE_W-1:0] limit,
   output logic             tick
);

   logic [PRE_W-1:0] cnt_q;
   logic [PRE_W-1:0] cnt_d;

   // Tick on reaching the limit; >= keeps a limit lowered mid-run from
   // stranding the count above it for a full wrap of the prescaler.
   always_comb begin
      tick  = run && (cnt_q >= limit);
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (run) begin
         cnt_d = tick ? '0 : cnt_q + 1'b1;
      end
   end

   // Prescaler count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/cntr_seq_ctrl.sv
// Wishbone-programmable sequencer for the user-area up counter. Loads a start
// value, paces counting through a prescaler, detects the terminal count and
// either stops or auto-reloads, raising a level interrupt on completion.
// Optional build macro CNTR_SEQ_PAUSE_EN adds the CTRL[4] PAUSE bit; without
// it CTRL[4] reads 0 and no pause logic exists.
module cntr_seq_ctrl
   import cntr_seq_pkg::*;
#(
   parameter int          CNT_W    = 9,
   parameter int          PRE_W    = 16,
   parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             wbs_cyc_i,
   input  logic             wbs_stb_i,
   input  logic             wbs_we_i,
   input  logic [3:0]       wbs_sel_i,
   input  logic [31:0]      wbs_adr_i,
   input  logic [31:0]      wbs_dat_i,
   output logic             wbs_ack_o,
   output logic [31:0]      wbs_dat_o,
   input  logic [CNT_W-1:0] cnt_val_i,
   output logic             cnt_load_o,
   output logic [CNT_W-1:0] cnt_load_val_o,
   output logic             cnt_en_o,
   output logic             irq_o
);

   logic             ack_q, ack_d;
   logic [31:0]      dat_q, dat_d;
   logic [1:0]       state_q, state_d;
   logic             autoreload_q, autoreload_d;
   logic             irq_en_q, irq_en_d;
   logic             done_q, done_d;
   logic             irq_q, irq_d;
   logic [PRE_W-1:0] prescale_q, prescale_d;
   logic [CNT_W-1:0] load_q, load_d;
   logic [CNT_W-1:0] term_q, term_d;

   logic        bus_req, addr_hit, wr_req;
   logic [7:0]  offset;
   logic [31:0] lane_mask, rdata;
   logic        start_cmd, stop_cmd, clr_done;
   logic        tick, term_hit, done_set;
   logic        pre_clr, pre_run, pause_act;
   logic        unused_bits;

   assign bus_req   = wbs_cyc_i && wbs_stb_i && !ack_q;
   assign addr_hit  = (wbs_adr_i[31:8] == BASE_ADR[31:8]);
   assign offset    = wbs_adr_i[7:0];
   assign wr_req    = bus_req && wbs_we_i && addr_hit;
   assign lane_mask = lane_mask_of(wbs_sel_i);

   assign start_cmd = wr_req && (offset == REG_CTRL) && wbs_sel_i[0] && wbs_dat_i[CTRL_START];
   assign stop_cmd  = wr_req && (offset == REG_CTRL) && wbs_sel_i[0] && wbs_dat_i[CTRL_STOP];
   assign clr_done  = wr_req && (offset == REG_STATUS) && wbs_sel_i[0] && wbs_dat_i[STAT_DONE];

   assign term_hit  = (cnt_val_i == term_q);
   assign done_set  = tick && term_hit;
   assign pre_clr   = (state_q != S_RUN);
   assign pre_run   = (state_q == S_RUN) && !pause_act;

   assign unused_bits = &{1'b0, wbs_dat_i, lane_mask};

`ifdef CNTR_SEQ_PAUSE_EN
   logic pause_q, pause_d;

   // PAUSE is a plain R/W control bit; it only freezes the prescaler in RUN.
   always_comb begin
      pause_d = pause_q;
      if (wr_req && (offset == REG_CTRL) && wbs_sel_i[0]) begin
         pause_d = wbs_dat_i[CTRL_PAUSE];
      end
   end

   // Pause bit register.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         pause_q <= 1'b0;
      end else begin
         pause_q <= pause_d;
      end
   end

   assign pause_act = pause_q;
`else
   assign pause_act = 1'b0;
`endif

   // Register file writes with byte lanes; a DONE set beats a same-cycle W1C.
   always_comb begin
      autoreload_d = autoreload_q;
      irq_en_d     = irq_en_q;
      prescale_d   = prescale_q;
      load_d       = load_q;
      term_d       = term_q;
      done_d       = done_q;
      if (wr_req && (offset == REG_CTRL) && wbs_sel_i[0]) begin
         autoreload_d = wbs_dat_i[CTRL_AUTO];
         irq_en_d     = wbs_dat_i[CTRL_IRQEN];
      end
      if (wr_req && (offset == REG_PRESCALE)) begin
         prescale_d = (prescale_q & ~lane_mask[PRE_W-1:0]) | (wbs_dat_i[PRE_W-1:0] & lane_mask[PRE_W-1:0]);
      end
      if (wr_req && (offset == REG_LOAD)) begin
         load_d = (load_q & ~lane_mask[CNT_W-1:0]) | (wbs_dat_i[CNT_W-1:0] & lane_mask[CNT_W-1:0]);
      end
      if (wr_req && (offset == REG_TERM)) begin
         term_d = (term_q & ~lane_mask[CNT_W-1:0]) | (wbs_dat_i[CNT_W-1:0] & lane_mask[CNT_W-1:0]);
      end
      if (clr_done) begin
         done_d = 1'b0;
      end
      if (done_set) begin
         done_d = 1'b1;
      end
      irq_d = done_q && irq_en_q;
   end

   // Read mux and single-cycle ack; unmapped or off-base addresses read 0.
   always_comb begin
      rdata = '0;
      if (addr_hit) begin
         case (offset)
            REG_CTRL: begin
               rdata[CTRL_AUTO]  = autoreload_q;
               rdata[CTRL_IRQEN] = irq_en_q;
               rdata[CTRL_PAUSE] = pause_act;
            end
            REG_PRESCALE: rdata[PRE_W-1:0] = prescale_q;
            REG_LOAD:     rdata[CNT_W-1:0] = load_q;
            REG_TERM:     rdata[CNT_W-1:0] = term_q;
            REG_STATUS: begin
               rdata[1:0]       = state_q;
               rdata[STAT_DONE] = done_q;
            end
            REG_COUNT:    rdata[CNT_W-1:0] = cnt_val_i;
            default:      rdata = '0;
         endcase
      end
      ack_d = bus_req;
      dat_d = (bus_req && !wbs_we_i) ? rdata : '0;
   end

   // FSM next state: STOP beats START, START restarts from any state.
   always_comb begin
      state_d = state_q;
      if (stop_cmd) begin
         state_d = S_IDLE;
      end else if (start_cmd) begin
         state_d = S_LOAD;
      end else begin
         case (state_q)
            S_LOAD: state_d = S_RUN;
            S_RUN: begin
               if (done_set) begin
                  state_d = autoreload_q ? S_LOAD : S_DONE;
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   // FSM outputs: load strobe in LOAD, increment strobe on non-terminal ticks.
   always_comb begin
      cnt_load_o     = (state_q == S_LOAD);
      cnt_load_val_o = cnt_load_o ? load_q : '0;
      cnt_en_o       = tick && !term_hit;
   end

   // State, register file and bus output flops.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q      <= S_IDLE;
         ack_q        <= 1'b0;
         dat_q        <= '0;
         autoreload_q <= 1'b0;
         irq_en_q     <= 1'b0;
         done_q       <= 1'b0;
         irq_q        <= 1'b0;
         prescale_q   <= '0;
         load_q       <= '0;
         term_q       <= '0;
      end else begin
         state_q      <= state_d;
         ack_q        <= ack_d;
         dat_q        <= dat_d;
         autoreload_q <= autoreload_d;
         irq_en_q     <= irq_en_d;
         done_q       <= done_d;
         irq_q        <= irq_d;
         prescale_q   <= prescale_d;
         load_q       <= load_d;
         term_q       <= term_d;
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;
   assign irq_o     = irq_q;

   cntr_seq_prescaler #(
      .PRE_W (PRE_W)
   ) u_prescaler (
      .clk   (wb_clk_i),
      .rst   (wb_rst_i),
      .clr   (pre_clr),
      .run   (pre_run),
      .limit (prescale_q),
      .tick  (tick)
   );

endmodule

// File: tb/tb_cntr_seq_ctrl.sv
// Directed bench for cntr_seq_ctrl. A behavioural 9-bit counter closes the
// loop on cnt_val_i; a monitor tallies load/increment strobes and their
// spacing so each step can be compared against hand-computed values.
module tb_cntr_seq_ctrl;

   localparam logic [31:0] BASE = 32'h3000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cyc = 1'b0;
   logic        stb = 1'b0;
   logic        we  = 1'b0;
   logic [3:0]  sel = 4'h0;
   logic [31:0] adr = 32'h0;
   logic [31:0] wdat = 32'h0;
   logic        ack;
   logic [31:0] rdat;
   logic [8:0]  cntVal;
   logic        loadStb;
   logic [8:0]  loadVal;
   logic        enStb;
   logic        irq;

   int total = 0;
   int bad = 0;

   int cycN = 0;
   int enCount = 0;
   int loadCount = 0;
   int enSinceLoad = 0;
   int lastEnCyc = 0;
   int lastLoadCyc = 0;
   int firstDelay = 0;
   int enGap = 0;
   int loadGap = 0;
   int irqRiseCyc = 0;
   logic [8:0] lastLoadVal = 9'h0;
   logic irqPrev = 1'b0;

   cntr_seq_ctrl dut (
      .wb_clk_i       (clk),
      .wb_rst_i       (rst),
      .wbs_cyc_i      (cyc),
      .wbs_stb_i      (stb),
      .wbs_we_i       (we),
      .wbs_sel_i      (sel),
      .wbs_adr_i      (adr),
      .wbs_dat_i      (wdat),
      .wbs_ack_o      (ack),
      .wbs_dat_o      (rdat),
      .cnt_val_i      (cntVal),
      .cnt_load_o     (loadStb),
      .cnt_load_val_o (loadVal),
      .cnt_en_o       (enStb),
      .irq_o          (irq)
   );

   // 100 MHz-style free-running clock.
   always #5 clk = ~clk;

   // Behavioural user-area counter: load has priority, wraps at 9 bits.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         cntVal <= 9'h0;
      end else if (loadStb) begin
         cntVal <= loadVal;
      end else if (enStb) begin
         cntVal <= cntVal + 9'd1;
      end
   end

   // Strobe monitor sampling mid-cycle; tracks counts and cycle spacing.
   always @(posedge clk) begin
      #2;
      cycN++;
      if (loadStb) begin
         if (loadCount > 0) loadGap = cycN - lastLoadCyc;
         loadCount++;
         lastLoadCyc = cycN;
         lastLoadVal = loadVal;
         enSinceLoad = 0;
      end
      if (enStb) begin
         if (enSinceLoad == 0) firstDelay = cycN - lastLoadCyc;
         if (enCount > 0) enGap = cycN - lastEnCyc;
         enCount++;
         enSinceLoad++;
         lastEnCyc = cycN;
      end
      if (irq && !irqPrev) irqRiseCyc = cycN;
      irqPrev = irq;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic wr, input logic [7:0] off, input logic [31:0] data,
                                input logic [3:0] lanes, output logic [31:0] rd);
      logic acked;
      acked = 1'b0;
      rd = 32'h0;
      @(negedge clk);
      cyc = 1'b1;
      stb = 1'b1;
      we = wr;
      adr = BASE | {24'h0, off};
      wdat = data;
      sel = lanes;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (ack) begin
            rd = rdat;
            acked = 1'b1;
            break;
         end
      end
      cyc = 1'b0;
      stb = 1'b0;
      we = 1'b0;
      if (!acked) checkOutput("ack_timeout", 32'h0, 32'h1);
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [31:0] rd;
      int e0;
      int l0;
      int acks;
      int dbl;
      logic prevAck;

      $display("[TB] start");
      waitCycles(2);
      checkOutput("rst_ack", 32'(ack), 32'h0);
      checkOutput("rst_dat", rdat, 32'h0);
      checkOutput("rst_load", 32'(loadStb), 32'h0);
      checkOutput("rst_loadval", 32'(loadVal), 32'h0);
      checkOutput("rst_en", 32'(enStb), 32'h0);
      checkOutput("rst_irq", 32'(irq), 32'h0);
      rst = 1'b0;
      applyStimulus(1'b0, 8'h10, 32'h0, 4'hF, rd);
      checkOutput("rst_status", rd, 32'h0);

      // One-shot run 5 -> 8 with no prescale.
      $display("[TB] one-shot run");
      applyStimulus(1'b1, 8'h08, 32'd5, 4'hF, rd);
      applyStimulus(1'b1, 8'h0C, 32'd8, 4'hF, rd);
      applyStimulus(1'b1, 8'h04, 32'd0, 4'hF, rd);
      e0 = enCount;
      l0 = loadCount;
      applyStimulus(1'b1, 8'h00, 32'h1, 4'hF, rd);
      checkOutput("os_load_now", 32'(loadStb), 32'h1);
      waitCycles(20);
      checkOutput("os_loads", 32'(loadCount - l0), 32'd1);
      checkOutput("os_loadval", 32'(lastLoadVal), 32'd5);
      checkOutput("os_ens", 32'(enCount - e0), 32'd3);
      checkOutput("os_first", 32'(firstDelay), 32'd1);
      checkOutput("os_irq", 32'(irq), 32'h0);
      applyStimulus(1'b0, 8'h10, 32'h0, 4'hF, rd);
      checkOutput("os_status", rd, 32'h7);
      applyStimulus(1'b0, 8'h14, 32'h0, 4'hF, rd);
      checkOutput("os_count", rd, 32'd8);
      applyStimulus(1'b1, 8'h10, 32'h4, 4'hF, rd);
      applyStimulus(1'b0, 8'h10, 32'h0, 4'hF, rd);
      checkOutput("os_w1c", rd, 32'h3);

      // Prescale of 3 with interrupt enabled.
      $display("[TB] prescale and irq");
      applyStimulus(1'b1, 8'h04, 32'd3, 4'hF, rd);
      e0 = enCount;
      applyStimulus(1'b1, 8'h00, 32'h9, 4'hF, rd);
      waitCycles(30);
      checkOutput("ps_ens", 32'(enCount - e0), 32'd3);
      checkOutput("ps_first", 32'(firstDelay), 32'd4);
      checkOutput("ps_gap", 32'(enGap), 32'd4);
      checkOutput("ps_irq", 32'(irq), 32'h1);
      checkOutput("ps_irq_lat", 32'(irqRiseCyc - lastEnCyc), 32'd6);
      applyStimulus(1'b1, 8'h10, 32'h4, 4'h1, rd);
      waitCycles(2);
      checkOutput("ps_irq_clr", 32'(irq), 32'h0);

      // Wrap through 511 -> 0 with auto-reload.
      $display("[TB] wrap and auto-reload");
      applyStimulus(1'b1, 8'h04, 32'd0, 4'hF, rd);
      applyStimulus(1'b1, 8'h08, 32'd510, 4'hF, rd);
      applyStimulus(1'b1, 8'h0C, 32'd1, 4'hF, rd);
      e0 = enCount;
      l0 = loadCount;
      applyStimulus(1'b1, 8'h00, 32'h5, 4'hF, rd);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (loadCount - l0 >= 3) break;
      end
      checkOutput("ar_loads", 32'(loadCount - l0), 32'd3);
      checkOutput("ar_ens", 32'(enCount - e0), 32'd6);
      checkOutput("ar_loadval", 32'(lastLoadVal), 32'd510);
      checkOutput("ar_period", 32'(loadGap), 32'd5);
      applyStimulus(1'b1, 8'h00, 32'h2, 4'hF, rd);
      applyStimulus(1'b0, 8'h10, 32'h0, 4'hF, rd);
      checkOutput("ar_stop_status", rd, 32'h4);
      applyStimulus(1'b1, 8'h10, 32'h4, 4'hF, rd);

      // START+STOP together, then restart while running.
      $display("[TB] collisions");
      applyStimulus(1'b1, 8'h08, 32'd0, 4'hF, rd);
      applyStimulus(1'b1, 8'h0C, 32'd100, 4'hF, rd);
      applyStimulus(1'b1, 8'h00, 32'h1, 4'hF, rd);
      waitCycles(5);
      applyStimulus(1'b1, 8'h00, 32'h3, 4'hF, rd);
      e0 = enCount;
      l0 = loadCount;
      waitCycles(5);
      checkOutput("col_no_en", 32'(enCount - e0), 32'd0);
      checkOutput("col_no_load", 32'(loadCount - l0), 32'd0);
      applyStimulus(1'b0, 8'h10, 32'h0, 4'hF, rd);
      checkOutput("col_idle", rd, 32'h0);
      applyStimulus(1'b1, 8'h00, 32'h1, 4'hF, rd);
      waitCycles(3);
      applyStimulus(1'b1, 8'h08, 32'd7, 4'hF, rd);
      applyStimulus(1'b1, 8'h00, 32'h1, 4'hF, rd);
      checkOutput("col_restart_load", 32'(loadStb), 32'h1);
      checkOutput("col_restart_val", 32'(loadVal), 32'd7);
      applyStimulus(1'b1, 8'h00, 32'h2, 4'hF, rd);

      // Bus corner cases: unmapped read, byte lanes, back-to-back strobes.
      $display("[TB] bus");
      applyStimulus(1'b0, 8'h20, 32'h0, 4'hF, rd);
      checkOutput("bus_unmapped", rd, 32'h0);
      applyStimulus(1'b1, 8'h08, 32'hFFFF_FFAB, 4'h1, rd);
      applyStimulus(1'b0, 8'h08, 32'h0, 4'hF, rd);
      checkOutput("bus_lane0", rd, 32'h0AB);
      applyStimulus(1'b1, 8'h08, 32'h0000_0100, 4'h2, rd);
      applyStimulus(1'b0, 8'h08, 32'h0, 4'hF, rd);
      checkOutput("bus_lane1", rd, 32'h1AB);
      applyStimulus(1'b0, 8'h0C, 32'h0, 4'hF, rd);
      checkOutput("bus_term", rd, 32'd100);
      @(negedge clk);
      cyc = 1'b1;
      stb = 1'b1;
      we = 1'b0;
      adr = BASE | 32'h14;
      acks = 0;
      dbl = 0;
      prevAck = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (ack) acks++;
         if (ack && prevAck) dbl++;
         prevAck = ack;
      end
      cyc = 1'b0;
      stb = 1'b0;
      checkOutput("b2b_acks", 32'(acks), 32'd3);
      checkOutput("b2b_double", 32'(dbl), 32'd0);

`ifdef CNTR_SEQ_PAUSE_EN
      $display("[TB] pause");
      applyStimulus(1'b1, 8'h08, 32'd0, 4'hF, rd);
      applyStimulus(1'b1, 8'h0C, 32'd300, 4'hF, rd);
      applyStimulus(1'b1, 8'h00, 32'h1, 4'hF, rd);
      waitCycles(3);
      applyStimulus(1'b1, 8'h00, 32'h10, 4'hF, rd);
      e0 = enCount;
      waitCycles(20);
      checkOutput("pause_no_en", 32'(enCount - e0), 32'd0);
      applyStimulus(1'b0, 8'h10, 32'h0, 4'hF, rd);
      checkOutput("pause_state", rd, 32'h2);
      applyStimulus(1'b0, 8'h00, 32'h0, 4'hF, rd);
      checkOutput("pause_ctrl", rd, 32'h10);
      applyStimulus(1'b1, 8'h00, 32'h0, 4'hF, rd);
      e0 = enCount;
      waitCycles(5);
      checkOutput("pause_resume", 32'(enCount - e0), 32'd5);
      applyStimulus(1'b1, 8'h00, 32'h2, 4'hF, rd);
`else
      $display("[TB] pause bit absent");
      applyStimulus(1'b1, 8'h00, 32'h10, 4'hF, rd);
      applyStimulus(1'b0, 8'h00, 32'h0, 4'hF, rd);
      checkOutput("pause_ctrl", rd, 32'h0);
`endif

      // Reset asserted mid-RUN with the interrupt pending.
      $display("[TB] reset mid-run");
      applyStimulus(1'b1, 8'h08, 32'd0, 4'hF, rd);
      applyStimulus(1'b1, 8'h0C, 32'd2, 4'hF, rd);
      applyStimulus(1'b1, 8'h00, 32'h9, 4'hF, rd);
      waitCycles(10);
      checkOutput("mr_irq_done", 32'(irq), 32'h1);
      applyStimulus(1'b1, 8'h0C, 32'd300, 4'hF, rd);
      applyStimulus(1'b1, 8'h00, 32'h9, 4'hF, rd);
      waitCycles(3);
      checkOutput("mr_pre_en", 32'(enStb), 32'h1);
      checkOutput("mr_pre_irq", 32'(irq), 32'h1);
      rst = 1'b1;
      #1;
      checkOutput("mr_ack", 32'(ack), 32'h0);
      checkOutput("mr_dat", rdat, 32'h0);
      checkOutput("mr_load", 32'(loadStb), 32'h0);
      checkOutput("mr_loadval", 32'(loadVal), 32'h0);
      checkOutput("mr_en", 32'(enStb), 32'h0);
      checkOutput("mr_irq", 32'(irq), 32'h0);
      waitCycles(2);
      rst = 1'b0;
      applyStimulus(1'b0, 8'h10, 32'h0, 4'hF, rd);
      checkOutput("mr_status", rd, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
